adc_tx_framer: RTL and testbench

ADC_TX_FRAMER -- requirements
Module: adc_tx_framer

---
 rtl/adc_tx_pkg.sv | 25 ++
 rtl/adc_tx_fifo.sv | 52 +++++
 rtl/adc_tx_framer.sv | 112 +++++++++++
 tb/tb_adc_tx_framer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_tx_pkg.sv
// Shared types and constants for the ADC-to-JTAG-UART byte framer.
// Each 10-bit sample becomes two tagged bytes: LO carries bits [4:0], HI carries bits [9:5].
package adc_tx_pkg;

  localparam int SAMPLE_W = 10;
  localparam int HALF_W   = 5;

  localparam logic [2:0] LO_TAG = 3'b000;
  localparam logic [2:0] HI_TAG = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } tx_state_e;

  function automatic logic [7:0] lo_byte(input logic [SAMPLE_W-1:0] d);
    return {LO_TAG, d[HALF_W-1:0]};
  endfunction

  function automatic logic [7:0] hi_byte(input logic [HALF_W-1:0] h);
    return {HI_TAG, h};
  endfunction

endpackage

// File: rtl/adc_tx_fifo.sv
// Sample buffer: synchronous FIFO with registered pointers and first-word-fall-through read.
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module adc_tx_fifo
  import adc_tx_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic              full
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));

endmodule

// File: rtl/adc_tx_framer.sv
// Buffers ADC samples and streams each one as a LO/HI byte pair over an Avalon JTAG UART write port.
// Optional macro ADC_TX_OVERFLOW_CNT_EN adds a saturating 16-bit drop_count output.
module adc_tx_framer
  import adc_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                jtag_uart_write,
  output logic [31:0]         jtag_uart_wdata,
  input  logic                jtag_uart_waitrequest,
  output logic                fifo_full,
  output logic                busy,
  output logic                overflow
`ifdef ADC_TX_OVERFLOW_CNT_EN
  ,
  output logic [15:0]         drop_count
`endif
);

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  tx_state_e           state;
  logic [7:0]          tx_byte;
  logic [HALF_W-1:0]   hi_bits;
  logic [SAMPLE_W-1:0] fifo_rdata;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                accept;
  logic                drop;

  assign accept    = jtag_uart_write & ~jtag_uart_waitrequest;
  assign fifo_pop  = ~fifo_empty & ((state == IDLE) | ((state == SEND_HI) & accept));
  // A full buffer still accepts a sample when a pop frees a slot in the same cycle.
  assign fifo_push = sample_valid & (~fifo_full | fifo_pop);
  assign drop      = sample_valid & fifo_full & ~fifo_pop;

  adc_tx_fifo #(
    .DATA_W    (SAMPLE_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(sample_data),
    .pop      (fifo_pop),
    .pop_data (fifo_rdata),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      jtag_uart_write <= 1'b0;
      tx_byte         <= '0;
      hi_bits         <= '0;
      overflow        <= 1'b0;
    end else begin
      overflow <= drop;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            tx_byte         <= lo_byte(fifo_rdata);
            hi_bits         <= fifo_rdata[SAMPLE_W-1:HALF_W];
            jtag_uart_write <= 1'b1;
            state           <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (accept) begin
            tx_byte <= hi_byte(hi_bits);
            state   <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (accept) begin
            if (!fifo_empty) begin
              tx_byte <= lo_byte(fifo_rdata);
              hi_bits <= fifo_rdata[SAMPLE_W-1:HALF_W];
              state   <= SEND_LO;
            end else begin
              jtag_uart_write <= 1'b0;
              state           <= IDLE;
            end
          end
        end
        default: begin
          jtag_uart_write <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

  assign jtag_uart_wdata = {24'h0, tx_byte};
  assign busy            = (state != IDLE);

`ifdef ADC_TX_OVERFLOW_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)     drop_count <= '0;
    else if (drop) drop_count <= sat_inc(drop_count);
  end
`endif

endmodule

// File: tb/tb_adc_tx_framer.sv
// Directed self-checking bench for adc_tx_framer (FIFO_DEPTH=4).
// Drop-count checks are active only when ADC_TX_OVERFLOW_CNT_EN is defined.
module tb_adc_tx_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [9:0]  sample_data;
  logic        jtag_uart_write;
  logic [31:0] jtag_uart_wdata;
  logic        jtag_uart_waitrequest;
  logic        fifo_full;
  logic        busy;
  logic        overflow;
`ifdef ADC_TX_OVERFLOW_CNT_EN
  logic [15:0] drop_count;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  logic [31:0] bytes[$];
  int stamps[$];

  always #10 clk = ~clk;

  adc_tx_framer #(.FIFO_DEPTH(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .sample_valid         (sample_valid),
    .sample_data          (sample_data),
    .jtag_uart_write      (jtag_uart_write),
    .jtag_uart_wdata      (jtag_uart_wdata),
    .jtag_uart_waitrequest(jtag_uart_waitrequest),
    .fifo_full            (fifo_full),
    .busy                 (busy),
    .overflow             (overflow)
`ifdef ADC_TX_OVERFLOW_CNT_EN
    ,
    .drop_count           (drop_count)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted byte with its cycle stamp, and count overflow-high cycles.
  always @(negedge clk) begin
    if (!reset && jtag_uart_write && !jtag_uart_waitrequest) begin
      bytes.push_back(jtag_uart_wdata);
      stamps.push_back(cyc);
    end
    if (overflow) ovf_cnt++;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    bytes.delete();
    stamps.delete();
    ovf_cnt = 0;
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bytes.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (bytes.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    sample_data = '0;
    jtag_uart_waitrequest = 1'b0;
    next();
    next();
    @(negedge clk);
    tests++;
    if (jtag_uart_write !== 1'b0) begin
      fails++; $display("FAIL reset_write: got %b want 0", jtag_uart_write);
    end
    tests++;
    if (jtag_uart_wdata !== 32'h0) begin
      fails++; $display("FAIL reset_wdata: got %h want 00000000", jtag_uart_wdata);
    end
    tests++;
    if ({fifo_full, busy, overflow} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got full/busy/ovf=%b want 000", {fifo_full, busy, overflow});
    end
`ifdef ADC_TX_OVERFLOW_CNT_EN
    tests++;
    if (drop_count !== 16'd0) begin
      fails++; $display("FAIL reset_drop_count: got %0d want 0", drop_count);
    end
`endif
    next();
    reset = 1'b0;
    next();
  endtask

  task automatic test_single();
    clear_mon();
    jtag_uart_waitrequest = 1'b0;
    next();
    sample_valid = 1'b1;
    sample_data = 10'h2A5;
    @(negedge clk);
    tests++;
    if (jtag_uart_write !== 1'b0) begin
      fails++; $display("FAIL single_p0_write: got %b want 0", jtag_uart_write);
    end
    next();
    sample_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (jtag_uart_write !== 1'b0) begin
      fails++; $display("FAIL single_p1_write: got %b want 0", jtag_uart_write);
    end
    next();
    @(negedge clk);
    tests++;
    if ({jtag_uart_write, jtag_uart_wdata} !== {1'b1, 32'h05}) begin
      fails++; $display("FAIL single_lo: got write=%b wdata=%h want write=1 wdata=00000005", jtag_uart_write, jtag_uart_wdata);
    end
    next();
    @(negedge clk);
    tests++;
    if ({jtag_uart_write, jtag_uart_wdata} !== {1'b1, 32'hF5}) begin
      fails++; $display("FAIL single_hi: got write=%b wdata=%h want write=1 wdata=000000f5", jtag_uart_write, jtag_uart_wdata);
    end
    next();
    @(negedge clk);
    tests++;
    if ({jtag_uart_write, busy} !== 2'b00) begin
      fails++; $display("FAIL single_done: got write/busy=%b want 00", {jtag_uart_write, busy});
    end
    tests++;
    if (bytes.size() !== 2) begin
      fails++; $display("FAIL single_count: got %0d bytes want 2", bytes.size());
    end
    next();
  endtask

  task automatic test_stall();
    clear_mon();
    jtag_uart_waitrequest = 1'b1;
    next();
    sample_valid = 1'b1;
    sample_data = 10'h2A5;
    next();
    sample_valid = 1'b0;
    next();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({jtag_uart_write, jtag_uart_wdata} !== {1'b1, 32'h05}) begin
        fails++; $display("FAIL stall_hold%0d: got write=%b wdata=%h want write=1 wdata=00000005", i, jtag_uart_write, jtag_uart_wdata);
      end
      next();
    end
    jtag_uart_waitrequest = 1'b0;
    @(negedge clk);
    tests++;
    if ({jtag_uart_write, jtag_uart_wdata} !== {1'b1, 32'h05}) begin
      fails++; $display("FAIL stall_accept_lo: got write=%b wdata=%h want write=1 wdata=00000005", jtag_uart_write, jtag_uart_wdata);
    end
    next();
    @(negedge clk);
    tests++;
    if ({jtag_uart_write, jtag_uart_wdata} !== {1'b1, 32'hF5}) begin
      fails++; $display("FAIL stall_hi: got write=%b wdata=%h want write=1 wdata=000000f5", jtag_uart_write, jtag_uart_wdata);
    end
    next();
    @(negedge clk);
    tests++;
    if (jtag_uart_write !== 1'b0) begin
      fails++; $display("FAIL stall_done: got write=%b want 0", jtag_uart_write);
    end
    next();
  endtask

  task automatic test_burst();
    logic [9:0]  vals [4];
    logic [31:0] want [8];
    logic [31:0] got;
    bit ok;
    vals = '{10'h000, 10'h3FF, 10'h155, 10'h2AA};
    want = '{32'h00, 32'hE0, 32'h1F, 32'hFF, 32'h15, 32'hEA, 32'h0A, 32'hF5};
    clear_mon();
    jtag_uart_waitrequest = 1'b0;
    next();
    for (int k = 0; k < 4; k++) begin
      sample_valid = 1'b1;
      sample_data = vals[k];
      next();
    end
    sample_valid = 1'b0;
    wait_bytes(8, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL burst_timeout: got %0d bytes want 8", bytes.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < bytes.size()) ? bytes[i] : 32'hxxxxxxxx;
      tests++;
      if (got !== want[i]) begin
        fails++; $display("FAIL burst_byte%0d: got %h want %h", i, got, want[i]);
      end
    end
    tests++;
    if (stamps.size() < 8 || (stamps[7] - stamps[0]) != 7) begin
      fails++; $display("FAIL burst_rate: got span %0d want 7", (stamps.size() >= 8) ? stamps[7] - stamps[0] : -1);
    end
    next();
    next();
    @(negedge clk);
    tests++;
    if (ovf_cnt !== 0) begin
      fails++; $display("FAIL burst_overflow: got %0d pulses want 0", ovf_cnt);
    end
    tests++;
    if ({bytes.size() == 8, busy} !== 2'b10) begin
      fails++; $display("FAIL burst_end: got bytes=%0d busy=%b want bytes=8 busy=0", bytes.size(), busy);
    end
    next();
  endtask

  task automatic test_overflow();
    logic [9:0]  vals [6];
    logic [31:0] want [10];
    logic [31:0] got;
    bit ok;
    vals = '{10'h022, 10'h044, 10'h066, 10'h088, 10'h0AA, 10'h0CC};
    want = '{32'h01, 32'hE0, 32'h02, 32'hE1, 32'h04, 32'hE2, 32'h06, 32'hE3, 32'h08, 32'hE4};
    clear_mon();
    jtag_uart_waitrequest = 1'b1;
    next();
    // Priming sample occupies the stalled FSM so the six that follow land in the buffer.
    sample_valid = 1'b1;
    sample_data = 10'h001;
    next();
    sample_valid = 1'b0;
    next();
    for (int k = 0; k < 6; k++) begin
      sample_valid = 1'b1;
      sample_data = vals[k];
      next();
    end
    sample_valid = 1'b0;
    @(negedge clk);
    next();
    @(negedge clk);
    tests++;
    if (ovf_cnt !== 2) begin
      fails++; $display("FAIL ovf_pulses: got %0d want 2", ovf_cnt);
    end
    tests++;
    if ({fifo_full, busy} !== 2'b11) begin
      fails++; $display("FAIL ovf_full_busy: got %b want 11", {fifo_full, busy});
    end
    tests++;
    if ({jtag_uart_write, jtag_uart_wdata} !== {1'b1, 32'h01}) begin
      fails++; $display("FAIL ovf_held: got write=%b wdata=%h want write=1 wdata=00000001", jtag_uart_write, jtag_uart_wdata);
    end
`ifdef ADC_TX_OVERFLOW_CNT_EN
    tests++;
    if (drop_count !== 16'd2) begin
      fails++; $display("FAIL ovf_drop_count: got %0d want 2", drop_count);
    end
`endif
    next();
    jtag_uart_waitrequest = 1'b0;
    wait_bytes(10, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL ovf_timeout: got %0d bytes want 10", bytes.size());
    end
    for (int i = 0; i < 10; i++) begin
      got = (i < bytes.size()) ? bytes[i] : 32'hxxxxxxxx;
      tests++;
      if (got !== want[i]) begin
        fails++; $display("FAIL ovf_byte%0d: got %h want %h", i, got, want[i]);
      end
    end
    next();
    next();
    @(negedge clk);
    tests++;
    if ({bytes.size() == 10, busy} !== 2'b10) begin
      fails++; $display("FAIL ovf_end: got bytes=%0d busy=%b want bytes=10 busy=0", bytes.size(), busy);
    end
    next();
  endtask

  task automatic test_reset_midframe();
    logic [31:0] got;
    bit ok;
    clear_mon();
    jtag_uart_waitrequest = 1'b0;
    next();
    sample_valid = 1'b1;
    sample_data = 10'h2A5;
    next();
    sample_valid = 1'b0;
    next();
    next();
    reset = 1'b1;
    jtag_uart_waitrequest = 1'b1;
    next();
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({jtag_uart_write, jtag_uart_wdata} !== {1'b0, 32'h0}) begin
      fails++; $display("FAIL rst_mid_write: got write=%b wdata=%h want write=0 wdata=00000000", jtag_uart_write, jtag_uart_wdata);
    end
    tests++;
    if ({fifo_full, busy, overflow} !== 3'b000) begin
      fails++; $display("FAIL rst_mid_flags: got full/busy/ovf=%b want 000", {fifo_full, busy, overflow});
    end
`ifdef ADC_TX_OVERFLOW_CNT_EN
    tests++;
    if (drop_count !== 16'd0) begin
      fails++; $display("FAIL rst_mid_drop_count: got %0d want 0", drop_count);
    end
`endif
    got = (bytes.size() > 0) ? bytes[0] : 32'hxxxxxxxx;
    tests++;
    if (bytes.size() != 1 || got !== 32'h05) begin
      fails++; $display("FAIL rst_mid_sent: got %0d bytes first=%h want 1 byte 00000005", bytes.size(), got);
    end
    clear_mon();
    jtag_uart_waitrequest = 1'b0;
    next();
    sample_valid = 1'b1;
    sample_data = 10'h01F;
    next();
    sample_valid = 1'b0;
    wait_bytes(2, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL rst_mid_timeout: got %0d bytes want 2", bytes.size());
    end
    got = (bytes.size() > 0) ? bytes[0] : 32'hxxxxxxxx;
    tests++;
    if (got !== 32'h1F) begin
      fails++; $display("FAIL rst_mid_lo: got %h want 0000001f", got);
    end
    got = (bytes.size() > 1) ? bytes[1] : 32'hxxxxxxxx;
    tests++;
    if (got !== 32'hE0) begin
      fails++; $display("FAIL rst_mid_hi: got %h want 000000e0", got);
    end
    next();
    next();
  endtask

  initial begin
    reset = 1'b1;
    sample_valid = 1'b0;
    sample_data = '0;
    jtag_uart_waitrequest = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_burst();
    test_overflow();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
